// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encodings and PC constants for the fetch controller
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4,
        S_FAULT = 3'd5
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect, instruction-memory and decode-side signals of the fetch controller
interface fetch_ctrl_if;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_ready_i;
    logic        fault_o;

    modport master (
        input  stall_i, redirect_valid_i, redirect_pc_i,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
        output imem_req_o, imem_addr_o, if_valid_o, if_inst_o, if_pc_o, fault_o
    );

    modport slave (
        output stall_i, redirect_valid_i, redirect_pc_i,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
        input  imem_req_o, imem_addr_o, if_valid_o, if_inst_o, if_pc_o, fault_o
    );
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - one-entry instruction/PC holding register toward decode
module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        flush,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc
);
    // Flush wins over a same-cycle handshake so a redirected-away instruction is never kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM; FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  redir_pc;
    logic         redir_fault;
    logic         redir;
    logic         req;
    logic         granted;
    logic         hs;
    logic         buf_load;
    logic         buf_valid;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign redir_pc    = bus.redirect_pc_i;
    assign redir_fault = bus.redirect_valid_i && (bus.redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst)              fault_q <= 1'b0;
        else if (redir_fault) fault_q <= 1'b1;
    end
    assign bus.fault_o = fault_q;
`else
    assign redir_pc    = align_word(bus.redirect_pc_i);
    assign redir_fault = 1'b0;
    assign bus.fault_o = 1'b0;
`endif

    assign redir   = bus.redirect_valid_i && !redir_fault;
    assign hs      = buf_valid && bus.if_ready_i;
    assign granted = req && bus.imem_gnt_i;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            // A grant coinciding with a redirect is already in flight and must be drained.
            S_REQ:   if (granted) state_nxt = redir ? S_DRAIN : S_WAIT;
            S_WAIT:  if (redir)                   state_nxt = bus.imem_rvalid_i ? S_REQ : S_DRAIN;
                     else if (bus.imem_rvalid_i)  state_nxt = S_HOLD;
            S_HOLD:  if (redir)        state_nxt = S_REQ;
                     else if (granted) state_nxt = S_WAIT;
                     else if (hs)      state_nxt = S_REQ;
            S_DRAIN: if (bus.imem_rvalid_i) state_nxt = S_REQ;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
        if (redir_fault) state_nxt = S_FAULT;
    end

    always_comb begin
        req = 1'b0;
        case (state)
            S_REQ:   req = !bus.stall_i && !redir_fault;
            S_HOLD:  req = hs && !bus.stall_i && !bus.redirect_valid_i;
            default: req = 1'b0;
        endcase
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = req ? pc : '0;

    always_ff @(posedge clk) begin
        if (rst)          pc <= RESET_PC;
        else if (redir)   pc <= redir_pc;
        else if (granted) pc <= pc + PC_INC;
    end

    // pc already advanced at grant and cannot move in WAIT without leaving it, so pc-4 is the fetched PC.
    assign buf_load = (state == S_WAIT) && bus.imem_rvalid_i && !bus.redirect_valid_i;

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_inst (bus.imem_rdata_i),
        .load_pc   (pc - PC_INC),
        .flush     (bus.redirect_valid_i),
        .ready     (bus.if_ready_i),
        .valid     (buf_valid),
        .inst      (buf_inst),
        .pc        (buf_pc)
    );

    assign bus.if_valid_o = buf_valid;
    assign bus.if_inst_o  = buf_inst;
    assign bus.if_pc_o    = buf_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic gnt, input logic rvalid, input logic [31:0] rdata,
                         input logic ready);
        @(negedge clk);
        bus.stall_i          = stall;
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = rpc;
        bus.imem_gnt_i       = gnt;
        bus.imem_rvalid_i    = rvalid;
        bus.imem_rdata_i     = rdata;
        bus.if_ready_i       = ready;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.stall_i = 0; bus.redirect_valid_i = 0; bus.redirect_pc_i = 0;
        bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = 0; bus.if_ready_i = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {31'd0, bus.imem_req_o}, 32'd0);
        chk("rst_addr",  bus.imem_addr_o, 32'd0);
        chk("rst_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("rst_inst",  bus.if_inst_o, 32'd0);
        chk("rst_pc",    bus.if_pc_o, 32'd0);
        chk("rst_fault", {31'd0, bus.fault_o}, 32'd0);

        // Sequential fetch 0x0, 0x4, 0x8
        @(negedge clk); rst = 1'b0; #1;
        chk("idle_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("seq0_req",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("seq0_addr", bus.imem_addr_o, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h1111_0000, 1);
        chk("wait_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("seq0_valid", {31'd0, bus.if_valid_o}, 32'd1);
        chk("seq0_inst",  bus.if_inst_o, 32'h1111_0000);
        chk("seq0_pc",    bus.if_pc_o, 32'h0);
        chk("seq1_addr",  bus.imem_addr_o, 32'h4);
        drive(0, 0, 0, 0, 1, 32'h1111_0004, 1);
        chk("seq1_valid_drop", {31'd0, bus.if_valid_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("seq1_inst", bus.if_inst_o, 32'h1111_0004);
        chk("seq1_pc",   bus.if_pc_o, 32'h4);
        chk("seq2_req",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("seq2_addr", bus.imem_addr_o, 32'h8);

        // Redirect in WAIT drops the pending response
        drive(0, 1, 32'h100, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        chk("drain_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("drain_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("drain_inst",  bus.if_inst_o, 32'h1111_0004);
        chk("redir_addr",  bus.imem_addr_o, 32'h100);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("redir_addr_gnt", bus.imem_addr_o, 32'h100);
        drive(0, 0, 0, 0, 1, 32'h2222_0100, 0);

        // Decode back-pressure holds outputs stable
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("hold_valid", {31'd0, bus.if_valid_o}, 32'd1);
            chk("hold_inst",  bus.if_inst_o, 32'h2222_0100);
            chk("hold_pc",    bus.if_pc_o, 32'h100);
            chk("hold_req",   {31'd0, bus.imem_req_o}, 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("hs_stall_req", {31'd0, bus.imem_req_o}, 32'd0);

        // Redirect while stalled
        drive(1, 1, 32'h200, 0, 0, 0, 1);
        chk("stall_redir_req", {31'd0, bus.imem_req_o}, 32'd0);
        chk("stall_valid",     {31'd0, bus.if_valid_o}, 32'd0);
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("stall_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("unstall_req",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("unstall_addr", bus.imem_addr_o, 32'h200);
        drive(0, 0, 0, 0, 1, 32'h3333_0200, 1);

        // Redirect in HOLD while handshaking drops the buffer
        drive(0, 1, 32'h300, 1, 0, 0, 1);
        chk("hold_redir_pc",  bus.if_pc_o, 32'h200);
        chk("hold_redir_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("hold_redir_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("hold_redir_addr",  bus.imem_addr_o, 32'h300);

        // Misaligned redirect
        drive(0, 1, 32'h102, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", {31'd0, bus.fault_o}, 32'd1);
        chk("mis_req",   {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("mis_fault_sticky", {31'd0, bus.fault_o}, 32'd1);
        chk("mis_req_stopped",  {31'd0, bus.imem_req_o}, 32'd0);
`else
        chk("mis_fault", {31'd0, bus.fault_o}, 32'd0);
        chk("mis_req",   {31'd0, bus.imem_req_o}, 32'd1);
        chk("mis_addr",  bus.imem_addr_o, 32'h100);
        drive(0, 0, 0, 0, 0, 0, 1);
`endif

        // Reset with an outstanding request, then a stale rvalid
        @(negedge clk); rst = 1'b1; bus.imem_gnt_i = 0;
        @(negedge clk); rst = 1'b0;
        bus.imem_rvalid_i = 1; bus.imem_rdata_i = 32'h0BAD_0BAD; #1;
        chk("rst2_fault", {31'd0, bus.fault_o}, 32'd0);
        chk("rst2_req",   {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 0, 1, 32'h0BAD_0BAD, 1);
        chk("rst2_addr", bus.imem_addr_o, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("stale_valid", {31'd0, bus.if_valid_o}, 32'd0);

        // PC wrap
        drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 1, 32'h4444_FFFC, 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("wrap_pc",    bus.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_inst",  bus.if_inst_o, 32'h4444_FFFC);
        chk("wrap_addr1", bus.imem_addr_o, 32'h0);

        // Redirect together with grant drains the in-flight fetch
        drive(0, 0, 0, 0, 1, 32'h5555_0000, 0);
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 32'h400, 1, 0, 0, 1);
        chk("gnt_redir_addr", bus.imem_addr_o, 32'h4);
        drive(0, 0, 0, 0, 1, 32'h0BAD_0BAD, 1);
        chk("gnt_redir_drain_req", {31'd0, bus.imem_req_o}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("gnt_redir_valid", {31'd0, bus.if_valid_o}, 32'd0);
        chk("gnt_redir_next",  bus.imem_addr_o, 32'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
